// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch front end.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int FETCH_WIDTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Decode may signal 3, which the queue honours as 2.
  function automatic logic [1:0] clamp_deq(input logic [1:0] d);
    return (d == 2'd3) ? 2'd2 : d;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue: two writes at tail, two reads at head, flush to empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     enq,
  input  fetch_entry_t             wr_entry_0,
  input  fetch_entry_t             wr_entry_1,
  input  logic [1:0]               deq_count,
  output fetch_entry_t             rd_entry_0,
  output fetch_entry_t             rd_entry_1,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;
  logic [CW-1:0] occ;
  logic [1:0]    req;
  logic [CW-1:0] eff;

  assign head_p1 = head + AW'(1);
  assign tail_p1 = tail + AW'(1);

  // Consumption is limited to what is actually held, so the queue never underflows.
  always_comb begin
    req = clamp_deq(deq_count);
    eff = (CW'(req) > occ) ? occ : CW'(req);
  end

  // Storage is deliberately left out of reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail]    <= wr_entry_0;
      mem[tail_p1] <= wr_entry_1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (enq) tail <= tail + AW'(2);
      head <= head + eff[AW-1:0];
      occ  <= occ + (enq ? CW'(2) : CW'(0)) - eff;
    end
  end

  assign rd_entry_0 = mem[head];
  assign rd_entry_1 = mem[head_p1];
  assign occupancy  = occ;

endmodule

// File: rtl/dual_fetch_unit.sv
// Fetch front end: owns the fetch PC, applies redirects and feeds a two-wide queue to decode.
module dual_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [31:0]            icache_pc,
  input  logic [31:0]            icache_instr_1,
  input  logic [31:0]            icache_instr_2,
  input  logic [31:0]            icache_pc_1,
  input  logic [31:0]            icache_pc_2,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic [1:0]             deq_count,
  output logic [31:0]            out_instr_0,
  output logic [31:0]            out_instr_1,
  output logic [31:0]            out_pc_0,
  output logic [31:0]            out_pc_1,
  output logic                   out_valid_0,
  output logic                   out_valid_1,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [31:0] PC_STEP  = 32'(FETCH_WIDTH * INSTR_BYTES);
  localparam logic [31:0] WORD_MSK = 32'hFFFF_FFFC;

  logic [31:0]  fetch_pc;
  logic         enq;
  fetch_entry_t wr_entry_0;
  fetch_entry_t wr_entry_1;
  fetch_entry_t rd_entry_0;
  fetch_entry_t rd_entry_1;

  // Handshake: out_valid_N marks slot N as offered; decode accepts by returning
  // deq_count in the same cycle, taking slots strictly in order (slot 0 first).
  // Space is judged on start-of-cycle occupancy; a redirect suppresses capture.
  assign enq = !redirect_valid && (occupancy <= CW'(DEPTH - 2));

  assign wr_entry_0 = '{instr: icache_instr_1, pc: icache_pc_1};
  assign wr_entry_1 = '{instr: icache_instr_2, pc: icache_pc_2};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC & WORD_MSK;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & WORD_MSK;
    end else if (enq) begin
      fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .enq        (enq),
    .wr_entry_0 (wr_entry_0),
    .wr_entry_1 (wr_entry_1),
    .deq_count  (deq_count),
    .rd_entry_0 (rd_entry_0),
    .rd_entry_1 (rd_entry_1),
    .occupancy  (occupancy)
  );

  assign icache_pc   = fetch_pc;
  assign out_instr_0 = rd_entry_0.instr;
  assign out_pc_0    = rd_entry_0.pc;
  assign out_instr_1 = rd_entry_1.instr;
  assign out_pc_1    = rd_entry_1.pc;
  assign out_valid_0 = (occupancy != '0);
  assign out_valid_1 = (occupancy >= CW'(2));

endmodule

// File: tb/tb_dual_fetch_unit.sv
// Bench for dual_fetch_unit: directed plan plus random traffic against a queue-based model.
module tb_dual_fetch_unit;

  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XMASK    = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic [31:0] icache_pc;
  logic [31:0] icache_instr_1;
  logic [31:0] icache_instr_2;
  logic [31:0] icache_pc_1;
  logic [31:0] icache_pc_2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  deq_count;
  logic [31:0] out_instr_0;
  logic [31:0] out_instr_1;
  logic [31:0] out_pc_0;
  logic [31:0] out_pc_1;
  logic        out_valid_0;
  logic        out_valid_1;
  logic [3:0]  occupancy;

  int n_cmp;
  int n_err;

  // Model state: expected queue contents {instr, pc} oldest first, and fetch address.
  logic [63:0] exp_q[$];
  logic [31:0] m_fpc;

  dual_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .icache_pc      (icache_pc),
    .icache_instr_1 (icache_instr_1),
    .icache_instr_2 (icache_instr_2),
    .icache_pc_1    (icache_pc_1),
    .icache_pc_2    (icache_pc_2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_count      (deq_count),
    .out_instr_0    (out_instr_0),
    .out_instr_1    (out_instr_1),
    .out_pc_0       (out_pc_0),
    .out_pc_1       (out_pc_1),
    .out_valid_0    (out_valid_0),
    .out_valid_1    (out_valid_1),
    .occupancy      (occupancy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction cache model: two sequential words at the requested address.
  assign icache_pc_1    = icache_pc;
  assign icache_pc_2    = icache_pc + 32'd4;
  assign icache_instr_1 = icache_pc_1 ^ XMASK;
  assign icache_instr_2 = icache_pc_2 ^ XMASK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_fpc = RESET_PC;
  endtask

  // One clock edge of the architectural behaviour, from the pre-edge inputs.
  task automatic model_step(input logic [1:0] dq, input logic rv, input logic [31:0] rpc);
    int occ;
    int want;
    int eff;
    if (rv) begin
      exp_q.delete();
      m_fpc = {rpc[31:2], 2'b00};
    end else begin
      occ  = exp_q.size();
      want = (dq == 2'd3) ? 2 : int'(dq);
      eff  = (want < occ) ? want : occ;
      for (int k = 0; k < eff; k++) void'(exp_q.pop_front());
      if (DEPTH - occ >= 2) begin
        exp_q.push_back({m_fpc ^ XMASK, m_fpc});
        exp_q.push_back({(m_fpc + 32'd4) ^ XMASK, m_fpc + 32'd4});
        m_fpc = m_fpc + 32'd8;
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] e0;
    logic [63:0] e1;
    chk("icache_pc", icache_pc, m_fpc);
    chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
    chk("out_valid_0", 32'(out_valid_0), 32'(exp_q.size() >= 1));
    chk("out_valid_1", 32'(out_valid_1), 32'(exp_q.size() >= 2));
    if (exp_q.size() >= 1) begin
      e0 = exp_q[0];
      chk("out_pc_0", out_pc_0, e0[31:0]);
      chk("out_instr_0", out_instr_0, e0[63:32]);
    end
    if (exp_q.size() >= 2) begin
      e1 = exp_q[1];
      chk("out_pc_1", out_pc_1, e1[31:0]);
      chk("out_instr_1", out_instr_1, e1[63:32]);
    end
  endtask

  // Driver: apply inputs away from the edge, clock once, advance model, check at negedge.
  task automatic step(input logic [1:0] dq, input logic rv, input logic [31:0] rpc);
    deq_count      = dq;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    model_step(dq, rv, rpc);
    @(negedge clk);
    deq_count      = 2'd0;
    redirect_valid = 1'b0;
    check_all();
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset          = 1'b0;
    deq_count      = 2'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_all();
    chk("reset_icache_pc", icache_pc, 32'h0);
    reset = 1'b1;

    // Fill with no decode consumption
    repeat (4) step(2'd0, 1'b0, 32'd0);
    chk("fill_occ", 32'(occupancy), 32'd8);
    chk("fill_icache_pc", icache_pc, 32'h20);
    chk("fill_pc_0", out_pc_0, 32'h0);
    chk("fill_pc_1", out_pc_1, 32'h4);
    step(2'd0, 1'b0, 32'd0);
    chk("full_hold_pc", icache_pc, 32'h20);

    // Steady two-wide drain across the pointer wrap
    for (int i = 0; i < 10; i++) begin
      chk("drain_pc_0", out_pc_0, 32'(8 * i));
      chk("drain_occ", 32'(occupancy), (i == 0) ? 32'd8 : 32'd6);
      step(2'd2, 1'b0, 32'd0);
    end

    // Odd dequeue from a queue holding 0x0..0x1C
    step(2'd0, 1'b1, 32'h0);
    repeat (4) step(2'd0, 1'b0, 32'd0);
    step(2'd1, 1'b0, 32'd0);
    chk("odd_pc_0", out_pc_0, 32'h4);
    chk("odd_pc_1", out_pc_1, 32'h8);
    chk("odd_occ", 32'(occupancy), 32'd7);

    // Redirect overrides a simultaneous dequeue
    step(2'd2, 1'b1, 32'h103);
    chk("redir_icache_pc", icache_pc, 32'h100);
    chk("redir_occ", 32'(occupancy), 32'd0);
    chk("redir_v0", 32'(out_valid_0), 32'd0);
    chk("redir_v1", 32'(out_valid_1), 32'd0);

    // Over-dequeue on an empty queue: nothing consumed, fetch still captured
    step(2'd2, 1'b0, 32'd0);
    chk("tgt_pc_0", out_pc_0, 32'h100);
    chk("tgt_pc_1", out_pc_1, 32'h104);
    chk("over_occ", 32'(occupancy), 32'd2);
    step(2'd3, 1'b0, 32'd0);
    chk("deq3_pc_0", out_pc_0, 32'h108);

    // Randomized traffic with occasional redirects
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0), $urandom);
    end

    // Asynchronous reset between edges while partly full
    step(2'd0, 1'b1, 32'h40);
    repeat (3) step(2'd0, 1'b0, 32'd0);
    chk("pre_rst_occ", 32'(occupancy), 32'd6);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_v0", 32'(out_valid_0), 32'd0);
    chk("async_rst_pc", icache_pc, RESET_PC);
    @(negedge clk);
    reset = 1'b1;
    step(2'd0, 1'b0, 32'd0);
    chk("refetch_pc_0", out_pc_0, 32'h0);
    chk("refetch_pc_1", out_pc_1, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
